// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its read-side packer.
package fifo_pkg;

  // Default FIFO word width and packer words-per-beat; the FIFO uses the same defaults.
  localparam int FIFO_N = 4;
  localparam int FIFO_K = 4;

  // Low-order mask with cnt ones, saturating at k ones.
  function automatic int unsigned keep_mask(input int cnt, input int k);
    int lim;
    lim = (cnt > k) ? k : cnt;
    if (lim <= 0) return 0;
    if (lim >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << lim) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Single-entry valid/ready output register carrying a packed beat, its keep mask and last flag.
module pack_out_reg #(
  parameter int W_DATA = 16,
  parameter int W_KEEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [W_DATA-1:0] in_data,
  input  logic [W_KEEP-1:0] in_keep,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [W_DATA-1:0] out_data,
  output logic [W_KEEP-1:0] out_keep,
  output logic              out_last
);

  logic              valid_reg;
  logic [W_DATA-1:0] data_reg;
  logic [W_KEEP-1:0] keep_reg;
  logic              last_reg;

  // Loading is allowed into an empty slot or into the slot being consumed this cycle,
  // so back-to-back beats leave no bubble.
  assign can_load = !valid_reg || out_ready;

  // Load a new beat, otherwise drop valid on consume; payload holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
      keep_reg  <= in_keep;
      last_reg  <= in_last;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_keep  = keep_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops N-bit words from a registered-read FIFO, packs K of them (first word in the LSBs)
// into one beat, and closes messages early on flush with a keep mask and last flag.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int N  = FIFO_N,
  parameter int K  = FIFO_K,
  parameter int CW = $clog2(K + 1)
) (
  input  logic           clk,
  input  logic           reset,
  output logic           fifo_rd_en,
  input  logic           fifo_empty,
  input  logic [N-1:0]   fifo_data,
  input  logic           flush,
  output logic           flush_busy,
  output logic [K*N-1:0] out_data,
  output logic [K-1:0]   out_keep,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [CW-1:0] K_CNT  = CW'(K);
  localparam logic [CW:0]   K_WIDE = (CW + 1)'(K);

  logic [N-1:0]   acc_reg [K];
  logic [CW-1:0]  acc_cnt_reg, acc_cnt_next;
  logic           rd_pend_reg;
  logic           flush_pend_reg, flush_pend_next;

  logic           can_load;
  logic           acc_full;
  logic           xfer_trig;
  logic           xfer;
  logic           acc_full_hold;
  logic [CW:0]    slots_used;
  logic [K*N-1:0] pack_data;
  logic [K-1:0]   pack_keep;
  logic           pack_last;

  assign acc_full      = (acc_cnt_reg == K_CNT);
  assign xfer_trig     = acc_full || (flush_pend_reg && !rd_pend_reg && (acc_cnt_reg != '0));
  assign xfer          = xfer_trig && can_load;
  assign acc_full_hold = acc_full && !can_load;

  // A transferring accumulator is empty next cycle, so its slots are free for a new read;
  // this keeps the only idle read cycle to the one just before the accumulator fills.
  assign slots_used = (xfer ? '0 : {1'b0, acc_cnt_reg}) + {{CW{1'b0}}, rd_pend_reg};
  assign fifo_rd_en = !reset && !fifo_empty && !flush_pend_reg &&
                      (slots_used < K_WIDE) && !acc_full_hold;

  assign flush_busy = flush_pend_reg;

  // A flush that coincides with a full-beat transfer is folded into that beat's last flag.
  assign pack_last = flush_pend_reg || flush;
  assign pack_keep = K'(keep_mask(int'(acc_cnt_reg), K));

  // Unfilled slots go out as zero so partial beats carry no stale words.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_pack
      assign pack_data[gi*N +: N] = (acc_cnt_reg > CW'(gi)) ? acc_reg[gi] : '0;
    end
  endgenerate

  // Next-state for the word counter and the pending-flush flag.
  always_comb begin
    acc_cnt_next    = acc_cnt_reg;
    flush_pend_next = flush_pend_reg;
    if (xfer) begin
      acc_cnt_next = '0;
    end else if (rd_pend_reg) begin
      acc_cnt_next = acc_cnt_reg + 1'b1;
    end
    if (flush_pend_reg) begin
      if (xfer || ((acc_cnt_reg == '0) && !rd_pend_reg)) begin
        flush_pend_next = 1'b0;
      end
    end else if (flush && !xfer) begin
      flush_pend_next = 1'b1;
    end
  end

  // Control state; reset drops any in-flight read and partial accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_reg    <= '0;
      rd_pend_reg    <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      acc_cnt_reg    <= acc_cnt_next;
      rd_pend_reg    <= fifo_rd_en;
      flush_pend_reg <= flush_pend_next;
    end
  end

  // Landing read data goes into the next free slot, preserving FIFO order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (rd_pend_reg && (acc_cnt_reg == CW'(i))) begin
        acc_reg[i] <= fifo_data;
      end
    end
  end

  pack_out_reg #(
    .W_DATA (K * N),
    .W_KEEP (K)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .in_data   (pack_data),
    .in_keep   (pack_keep),
    .in_last   (pack_last),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

endmodule
